// File: rtl/yubex_tiny_pattern_generator.sv
// Tiny pattern generator: a debounced button cycles through four output modes
// (low, high, square, LFSR) at a selectable tick rate, with the mode shown on a 7-segment digit.
module yubex_tiny_pattern_generator #(
  parameter logic [13:0] CLK_FREQ_HZ     = 14'd12500,
  parameter int          DEBOUNCE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [1:0] rate_sel,
  input  logic       run,
  output logic [6:0] seg,
  output logic       pattern_out
);

  typedef enum logic [1:0] {
    MODE_LOW    = 2'd0,
    MODE_HIGH   = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_LFSR   = 2'd3
  } mode_e;

  localparam logic [5:0] DB_LAST   = 6'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] LFSR_SEED = 8'h01;

  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        btn_stable_q, btn_stable_d;
  logic        btn_prev_q, btn_prev_d;
  logic [5:0]  db_cnt_q, db_cnt_d;
  mode_e       mode_q, mode_d;
  logic [13:0] tick_cnt_q, tick_cnt_d;
  logic        sq_q, sq_d;
  logic [7:0]  lfsr_q, lfsr_d;

  logic        advance;
  logic        tick;
  logic [13:0] period_m1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      btn_stable_q <= 1'b0;
      btn_prev_q   <= 1'b0;
      db_cnt_q     <= '0;
      mode_q       <= MODE_LOW;
      tick_cnt_q   <= '0;
      sq_q         <= 1'b0;
      lfsr_q       <= LFSR_SEED;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      btn_stable_q <= btn_stable_d;
      btn_prev_q   <= btn_prev_d;
      db_cnt_q     <= db_cnt_d;
      mode_q       <= mode_d;
      tick_cnt_q   <= tick_cnt_d;
      sq_q         <= sq_d;
      lfsr_q       <= lfsr_d;
    end
  end

  // The debounce counter only runs while the synchronized input disagrees with the accepted level.
  always_comb begin
    s1_d         = btn;
    s2_d         = s1_q;
    btn_prev_d   = btn_stable_q;
    btn_stable_d = btn_stable_q;
    db_cnt_d     = db_cnt_q;
    if (s2_q == btn_stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      btn_stable_d = s2_q;
      db_cnt_d     = '0;
    end else begin
      db_cnt_d = db_cnt_q + 6'd1;
    end
  end

  assign advance = btn_stable_q & ~btn_prev_q;

  always_comb begin
    period_m1 = 14'd0;
    case (rate_sel)
      2'b00:   period_m1 = 14'd0;
      2'b01:   period_m1 = 14'd15;
      2'b10:   period_m1 = 14'd255;
      default: period_m1 = CLK_FREQ_HZ - 14'd1;
    endcase
  end

  assign tick = run & (tick_cnt_q >= period_m1);

  // A mode advance restarts the generators and swallows any tick landing on the same edge.
  always_comb begin
    mode_d     = mode_q;
    tick_cnt_d = tick_cnt_q + 14'd1;
    sq_d       = sq_q;
    lfsr_d     = lfsr_q;
    if (advance) begin
      mode_d     = mode_e'(mode_q + 2'd1);
      tick_cnt_d = '0;
      sq_d       = 1'b0;
      lfsr_d     = LFSR_SEED;
    end else if (!run) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = '0;
      sq_d       = ~sq_q;
      lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_comb begin
    pattern_out = 1'b0;
    seg         = 7'h3F;
    case (mode_q)
      MODE_LOW: begin
        pattern_out = 1'b0;
        seg         = 7'h3F;
      end
      MODE_HIGH: begin
        pattern_out = 1'b1;
        seg         = 7'h06;
      end
      MODE_SQUARE: begin
        pattern_out = sq_q;
        seg         = 7'h5B;
      end
      MODE_LFSR: begin
        pattern_out = lfsr_q[7];
        seg         = 7'h4F;
      end
      default: begin
        pattern_out = 1'b0;
        seg         = 7'h3F;
      end
    endcase
  end

endmodule
